tangram_layer_compositor: RTL and testbench
===========================================

// Module: tangram_layer_compositor
// PURPOSE
//  Parametrised successor of the tangram display mixer. Merges NUM_LAYERS per-pixel shape hit
//  bits into 12-bit VGA RGB using a programmable per-layer palette and a runtime z-order (no
//  OR-blending). Selected piece can be raised to top and blinks. Sits between shape modules and VGA pins.
// PARAMETERS
//  NUM_LAYERS  8           number of shape layers (2..16)
//  COLOR_W     4           bits per colour channel
//  BLINK_DIV   25_000_000  clk cycles per blink half-period (>=2)
//  BG_COLOR    0           {r,g,b} colour when vidon=1 and no layer hit (3*COLOR_W bits)
// PORTS
//  clk        in   1              pixel/system clock
//  rst        in   1              synchronous, active-high reset
//  vidon      in   1              active-video flag, aligned with layer_hit
//  layer_hit  in   NUM_LAYERS     bit i = layer i covers current pixel
//  sel        in   NUM_LAYERS     one-hot selected layer (btn); 0 = none
//  raise      in   1              1-cycle pulse: move selected layer to top of z-order
//  pal_we     in   1              palette write strobe
//  pal_addr   in   clog2(NUM_LAYERS) palette entry
//  pal_data   in   3*COLOR_W      {r,g,b} written on pal_we
//  busy       out  1              z-order reorder in progress
//  red/green/blue out COLOR_W each  registered output colour
// BEHAVIOUR
//  Reset: red/green/blue=0, busy=0, FSM=IDLE, blink counter=0, phase=0, pipeline cleared,
//   z-order = identity (zpos k holds layer NUM_LAYERS-1-k; highest index on top),
//   palette[i]: r all-ones if (i%8) bit2, g if bit1, b if bit0, else 0.
//  Sel valid only if exactly one bit set; otherwise treated as "none".
//  Pipeline (latency 2): S1 registers vidon and index of top-most hit layer (scan zpos 0 up),
//   plus hit-flag; S2 registers colour. Output at edge t+2 reflects inputs sampled at edge t.
//   S2 colour: vidon=0 -> 0; no hit -> BG_COLOR; else palette[idx], bitwise inverted when
//   idx==selected layer and phase=1. Pipeline runs every cycle, incl. while busy.
//  Palette: pal_we writes at edge t; S2 uses new value from edge t+1. pal_addr>=NUM_LAYERS ignored.
//  Blink: counter 0..BLINK_DIV-1, wraps and toggles phase. If sel none, counter held at 0, phase=0.
//  Z-order FSM:
//   IDLE: raise & valid sel & sel layer not at zpos 0 -> capture position p, busy=1, go SHIFT.
//         raise with invalid sel or layer already on top -> ignored, stay IDLE.
//   SHIFT: per cycle swap zpos p with p-1, p<=p-1; after swap into zpos 0 -> IDLE, busy=0
//         on next cycle. Reorder of position p takes p cycles; busy high exactly p cycles.
//   raise while busy ignored. sel changes during SHIFT do not affect the move in progress.
//   S1 uses the live z-order each cycle (intermediate orders are valid permutations).
//  rst asserted mid-SHIFT: order returns to identity, IDLE, busy=0 next cycle.
//  Simultaneous pal_we and raise: both take effect independently.
// TESTING
//  1 Reset, vidon=1, layer_hit=8'h10 -> after 2 clk rgb={F,0,0}; layer_hit=0 -> BG_COLOR.
//  2 layer_hit=8'h06 (layers 1,2) -> layer 2 wins: {0,F,0}; vidon=0 -> {0,0,0} 2 cycles later.
//  3 sel=8'h02, raise pulse -> busy high 6 cycles (layer1 at zpos 6); then hit=8'h06 -> {0,0,F}.
//  4 pal_we addr=3 data=12'h5A3, hit=8'h08 -> {5,A,3}; sel=8'h08 -> inverted {A,5,C} after BLINK_DIV.
//  5 raise with sel=8'h03 or sel=8'h80 (already top) -> busy stays 0, order unchanged.
//  6 rst asserted 2 cycles into a SHIFT -> busy=0, rgb=0, identity order restored, palette reset.

Source files
------------

// File: rtl/tangram_layer_compositor.sv
// tangram_layer_compositor: z-ordered palette mixer of shape hit bits into VGA RGB with raise-to-top and blink
module tangram_layer_compositor #(
  parameter int NUM_LAYERS = 8,
  parameter int COLOR_W = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter logic [3*COLOR_W-1:0] BG_COLOR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vidon,
  input  logic [NUM_LAYERS-1:0]         layer_hit,
  input  logic [NUM_LAYERS-1:0]         sel,
  input  logic                          raise,
  input  logic                          pal_we,
  input  logic [$clog2(NUM_LAYERS)-1:0] pal_addr,
  input  logic [3*COLOR_W-1:0]          pal_data,
  output logic                          busy,
  output logic [COLOR_W-1:0]            red,
  output logic [COLOR_W-1:0]            green,
  output logic [COLOR_W-1:0]            blue
);
  localparam int IW = $clog2(NUM_LAYERS);
  localparam int CW = 3 * COLOR_W;
  localparam int BW = $clog2(BLINK_DIV);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] zord [NUM_LAYERS];
  logic [CW-1:0] pal [NUM_LAYERS];
  logic [IW-1:0] p, pm, sel_idx, sel_pos, top_idx, i1;
  logic [BW-1:0] cnt;
  logic phase, sel_ok, top_hit, v1, h1;
  logic [CW-1:0] color_nxt;
  function automatic logic [CW-1:0] pal_init(input int i);
    logic [2:0] b;
    b = 3'(i % 8);
    return {{COLOR_W{b[2]}}, {COLOR_W{b[1]}}, {COLOR_W{b[0]}}};
  endfunction
  always_comb begin
    sel_ok = sel != '0 && (sel & (sel - NUM_LAYERS'(1))) == '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_LAYERS; i++) if (sel[i]) sel_idx = IW'(i);
    sel_pos = '0;
    for (int k = 0; k < NUM_LAYERS; k++) if (zord[k] == sel_idx) sel_pos = IW'(k);
    top_hit = 1'b0;
    top_idx = '0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--)
      if (layer_hit[zord[k]]) begin
        top_hit = 1'b1;
        top_idx = zord[k];
      end
    pm = p - IW'(1);
    color_nxt = !v1 ? '0 : !h1 ? BG_COLOR :
                (sel_ok && phase && i1 == sel_idx) ? ~pal[i1] : pal[i1];
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (raise && sel_ok && sel_pos != '0) ? SHIFT : IDLE;
    else state_nxt = (p == IW'(1)) ? IDLE : SHIFT;
  end
  assign busy = state == SHIFT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p <= '0;
      cnt <= '0;
      phase <= 1'b0;
      v1 <= 1'b0;
      h1 <= 1'b0;
      i1 <= '0;
      {red, green, blue} <= '0;
      for (int k = 0; k < NUM_LAYERS; k++) zord[k] <= IW'(NUM_LAYERS - 1 - k);
      for (int i = 0; i < NUM_LAYERS; i++) pal[i] <= pal_init(i);
    end else begin
      state <= state_nxt;
      if (state == IDLE) p <= sel_pos;
      else begin
        zord[p] <= zord[pm];
        zord[pm] <= zord[p];
        p <= pm;
      end
      for (int i = 0; i < NUM_LAYERS; i++) if (pal_we && pal_addr == IW'(i)) pal[i] <= pal_data;
      if (!sel_ok) begin
        cnt <= '0;
        phase <= 1'b0;
      end else if (cnt == BW'(BLINK_DIV - 1)) begin
        cnt <= '0;
        phase <= ~phase;
      end else cnt <= cnt + BW'(1);
      v1 <= vidon;
      h1 <= top_hit;
      i1 <= top_idx;
      {red, green, blue} <= color_nxt;
    end
  end
endmodule

// File: tb/tb_tangram_layer_compositor.sv
// tb_tangram_layer_compositor: directed scenarios plus random traffic against a cycle-level behavioural model
module tb_tangram_layer_compositor;
  localparam int BD = 6;
  localparam logic [11:0] BG = 12'h2C7;
  logic clk = 0, rst = 1, vidon = 0, raise = 0, pal_we = 0;
  logic [7:0] hit = 0, sel = 0;
  logic [2:0] pal_addr = 0;
  logic [11:0] pal_data = 0;
  logic busy;
  logic [3:0] red, green, blue;
  int checks = 0, errors = 0;
  int mz [8];
  logic [11:0] mpal [8];
  logic mbusy, mphase, mv1, mh1;
  int mp, mcnt, mi1;
  logic [11:0] erg;

  tangram_layer_compositor #(.NUM_LAYERS(8), .COLOR_W(4), .BLINK_DIV(BD), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .vidon(vidon), .layer_hit(hit), .sel(sel), .raise(raise),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data), .busy(busy),
    .red(red), .green(green), .blue(blue));

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mz[k] = 7 - k;
      mpal[k] = {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    end
    mbusy = 0; mp = 0; mcnt = 0; mphase = 0;
    mv1 = 0; mh1 = 0; mi1 = 0; erg = 0;
  endtask

  task automatic tick();
    logic [11:0] c;
    logic sv, th;
    int si, ti, q, t;
    @(posedge clk);
    sv = $countones(sel) == 1;
    si = 0;
    for (int i = 0; i < 8; i++) if (sel[i]) si = i;
    th = 0; ti = 0;
    for (int k = 0; k < 8; k++) if (!th && hit[mz[k]]) begin th = 1; ti = mz[k]; end
    c = !mv1 ? 12'h000 : !mh1 ? BG : mpal[mi1];
    if (mv1 && mh1 && sv && mphase && mi1 == si) c = ~c;
    if (rst) model_reset();
    else begin
      erg = c; mv1 = vidon; mh1 = th; mi1 = ti;
      if (pal_we) mpal[pal_addr] = pal_data;
      if (!sv) begin mcnt = 0; mphase = 0; end
      else if (mcnt == BD - 1) begin mcnt = 0; mphase = !mphase; end
      else mcnt++;
      if (mbusy) begin
        t = mz[mp]; mz[mp] = mz[mp-1]; mz[mp-1] = t;
        mp--;
        if (mp == 0) mbusy = 0;
      end else if (raise && sv) begin
        q = 0;
        for (int k = 0; k < 8; k++) if (mz[k] == si) q = k;
        if (q != 0) begin mbusy = 1; mp = q; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; raise = 0; pal_we = 0; sel = 0; vidon = 0; hit = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({red, green, blue} !== 12'h000 || busy !== 1'b0) begin
      errors++; $display("FAIL reset rgb=%h busy=%b exp rgb=000 busy=0", {red, green, blue}, busy);
    end
    vidon = 1; hit = 8'h10;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'hF00) begin
      errors++; $display("FAIL layer4_red rgb=%h exp=F00", {red, green, blue});
    end
    hit = 8'h00;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== BG) begin
      errors++; $display("FAIL background rgb=%h exp=%h", {red, green, blue}, BG);
    end
  endtask

  task automatic test_priority();
    hit = 8'h06;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      errors++; $display("FAIL priority rgb=%h exp=0F0", {red, green, blue});
    end
    vidon = 0;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL blanking rgb=%h exp=000", {red, green, blue});
    end
  endtask

  task automatic test_raise();
    int n;
    vidon = 1; hit = 8'h00; sel = 8'h02; raise = 1;
    tick();
    raise = 0; sel = 8'h00;
    n = 0;
    while (busy && n < 20) begin n++; tick(); end
    checks++;
    if (n !== 6) begin
      errors++; $display("FAIL raise_busy_cycles got=%0d exp=6", n);
    end
    hit = 8'h06;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'h00F || {red, green, blue} !== erg) begin
      errors++; $display("FAIL raised_on_top rgb=%h exp=00F", {red, green, blue});
    end
  endtask

  task automatic test_palette();
    logic seen;
    pal_we = 1; pal_addr = 3; pal_data = 12'h5A3; hit = 8'h08;
    tick();
    pal_we = 0;
    tick();
    checks++;
    if ({red, green, blue} !== 12'h5A3) begin
      errors++; $display("FAIL palette_write rgb=%h exp=5A3", {red, green, blue});
    end
    sel = 8'h08; seen = 0;
    for (int i = 0; i < 3 * BD; i++) begin
      tick();
      if ({red, green, blue} === 12'hA5C) seen = 1;
      checks++;
      if ({red, green, blue} !== erg) begin
        errors++; $display("FAIL blink_cycle%0d rgb=%h exp=%h", i, {red, green, blue}, erg);
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL blink_inverted seen=%b exp=1", seen);
    end
    sel = 8'h00;
  endtask

  task automatic test_invalid_raise();
    logic [7:0] tries [2];
    do_reset();
    tries[0] = 8'h03; tries[1] = 8'h80;
    vidon = 1; hit = 8'hFF;
    for (int j = 0; j < 2; j++) begin
      sel = tries[j]; raise = 1;
      tick();
      raise = 0;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL ignored_raise sel=%h busy=%b exp=0", tries[j], busy);
        end
        tick();
      end
    end
    sel = 0;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      errors++; $display("FAIL order_unchanged rgb=%h exp=FFF", {red, green, blue});
    end
  endtask

  task automatic test_reset_mid_shift();
    pal_we = 1; pal_addr = 0; pal_data = 12'h9B1;
    vidon = 1; hit = 8'h01; sel = 8'h01; raise = 1;
    tick();
    pal_we = 0; raise = 0;
    tick(); tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL shift_running busy=%b exp=1", busy);
    end
    rst = 1;
    tick();
    rst = 0; sel = 0;
    checks++;
    if (busy !== 1'b0 || {red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL mid_shift_reset busy=%b rgb=%h exp busy=0 rgb=000", busy, {red, green, blue});
    end
    hit = 8'h81;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      errors++; $display("FAIL identity_restored rgb=%h exp=FFF", {red, green, blue});
    end
    hit = 8'h01;
    tick(); tick();
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++; $display("FAIL palette_restored rgb=%h exp=000", {red, green, blue});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      vidon = ($urandom_range(0, 9) != 0);
      hit = 8'($urandom);
      case ($urandom_range(0, 3))
        0: sel = 8'h00;
        1: sel = 8'($urandom);
        default: sel = 8'h01 << $urandom_range(0, 7);
      endcase
      raise = ($urandom_range(0, 5) == 0);
      pal_we = ($urandom_range(0, 7) == 0);
      pal_addr = 3'($urandom);
      pal_data = 12'($urandom);
      rst = ($urandom_range(0, 150) == 0);
      tick();
      checks++;
      if ({red, green, blue} !== erg || busy !== mbusy) begin
        errors++;
        $display("FAIL random_cycle%0d rgb=%h busy=%b exp rgb=%h busy=%b", i, {red, green, blue}, busy, erg, mbusy);
      end
    end
    rst = 0; raise = 0; pal_we = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_priority();
    test_raise();
    test_palette();
    test_invalid_raise();
    test_reset_mid_shift();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
